interp_mac_seq: RTL and testbench

- Sequencer for a time-multiplexed polyphase interpolation filter. One multiplier and one accumulator are shared across all taps and phases.
- For each accepted input sample, produces INTERP output samples, one per phase. Each output is the NUM_TAPS-tap dot product of the delay line with that phase's coefficients, scaled by COEF_FRAC and saturated to DATA_WIDTH.
- Sits between the upstream sample source and the downstream output stage, using valid/ready handshakes on both sides.

---
 rtl/interp_mac_seq.sv | 132 +++++++++++++
 tb/tb_interp_mac_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_mac_seq.sv
// Polyphase interpolation MAC sequencer: one shared multiplier/accumulator walks all taps of each phase.
// Latency: first phase valid NUM_TAPS cycles after input acceptance; each phase costs NUM_TAPS MAC cycles plus one output cycle.
// Backpressure: in_ready only in IDLE; out_valid/out_data held until out_ready, stalling the whole sequence.
module interp_mac_seq #(
  parameter int DATA_WIDTH = 6,
  parameter int COEF_WIDTH = 6,
  parameter int COEF_FRAC  = 4,
  parameter int NUM_TAPS   = 4,
  parameter int INTERP     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [DATA_WIDTH-1:0]          in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [INTERP*NUM_TAPS*COEF_WIDTH-1:0] coef,
  output logic signed [DATA_WIDTH-1:0]          out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy
);

  // Accumulator is wide enough for NUM_TAPS full-precision products, so it never overflows.
  localparam int PRODW = DATA_WIDTH + COEF_WIDTH;
  localparam int ACCW  = PRODW + $clog2(NUM_TAPS);
  localparam int TAPW  = $clog2(NUM_TAPS);
  localparam int PHW   = $clog2(INTERP);

  localparam logic [TAPW-1:0] TAP_LAST   = TAPW'(NUM_TAPS - 1);
  localparam logic [PHW-1:0]  PHASE_LAST = PHW'(INTERP - 1);

  // Saturation bounds expressed at accumulator width: 2^(DW-1)-1 and -2^(DW-1).
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                      r_state;
  logic [TAPW-1:0]             r_tap;
  logic [PHW-1:0]              r_phase;
  logic signed [ACCW-1:0]      r_acc;
  logic signed [DATA_WIDTH-1:0] r_x [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] r_out_data;
  logic                        r_out_valid;

  logic signed [DATA_WIDTH-1:0] w_x;
  logic signed [COEF_WIDTH-1:0] w_c;
  logic signed [PRODW-1:0]      w_prod;
  logic signed [ACCW-1:0]       w_sum;
  logic signed [ACCW-1:0]       w_shift;
  logic signed [DATA_WIDTH-1:0] w_sat;

  // Datapath: select tap sample and phase coefficient, multiply-accumulate, scale and saturate.
  always_comb begin
    w_x     = r_x[r_tap];
    w_c     = coef[(int'(r_phase) * NUM_TAPS + int'(r_tap)) * COEF_WIDTH +: COEF_WIDTH];
    w_prod  = PRODW'(w_x) * PRODW'(w_c);
    w_sum   = r_acc + ACCW'(w_prod);
    w_shift = w_sum >>> COEF_FRAC;
    if (w_shift >= SAT_MAX) begin
      w_sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      w_sat = w_shift[DATA_WIDTH-1:0];
    end
  end

  // Sequencer: accept a sample, run NUM_TAPS MACs per phase, present each phase until handshaked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tap       <= '0;
      r_phase     <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_x[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x[0] <= in_data;
            for (int i = 1; i < NUM_TAPS; i++) begin
              r_x[i] <= r_x[i-1];
            end
            r_acc   <= '0;
            r_tap   <= '0;
            r_phase <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          if (r_tap == TAP_LAST) begin
            r_out_data  <= w_sat;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_tap <= r_tap + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_phase == PHASE_LAST) begin
              r_state <= S_IDLE;
            end else begin
              r_phase <= r_phase + 1'b1;
              r_acc   <= '0;
              r_tap   <= '0;
              r_state <= S_MAC;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_interp_mac_seq.sv
// Testbench for interp_mac_seq: directed scenarios plus randomized streams against an arithmetic reference model.
module tb_interp_mac_seq;

  localparam int DW = 6;
  localparam int CW = 6;
  localparam int CF = 4;
  localparam int NT = 4;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic signed [DW-1:0]     in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [NI*NT*CW-1:0]      coef;
  logic signed [DW-1:0]     out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  interp_mac_seq #(
    .DATA_WIDTH(DW), .COEF_WIDTH(CW), .COEF_FRAC(CF), .NUM_TAPS(NT), .INTERP(NI)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef(coef),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int coefs [NI*NT];
  int hist  [NT];
  int exp_q [$];
  int stim  [$];
  int outs  [$];
  int acc_edges   [$];
  int valid_edges [$];
  bit tmo;

  // ---------------- reference model ----------------
  function automatic int floor_div(int a, int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int sat(int s);
    int hi, lo;
    hi = (1 << (DW - 1)) - 1;
    lo = -(1 << (DW - 1));
    if (s >= hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  // New sample enters the history; one expected output per phase is queued.
  task automatic model_push(input int s);
    int sum;
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    for (int p = 0; p < NI; p++) begin
      sum = 0;
      for (int k = 0; k < NT; k++) sum += hist[k] * coefs[p*NT + k];
      exp_q.push_back(sat(floor_div(sum, 1 << CF)));
    end
  endtask

  task automatic set_coefs();
    int v;
    for (int i = 0; i < NI*NT; i++) begin
      v = coefs[i];
      coef[i*CW +: CW] = v[CW-1:0];
    end
  endtask

  task automatic rand_coefs();
    for (int i = 0; i < NI*NT; i++) coefs[i] = $urandom_range(0, 63) - 32;
    set_coefs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NT; k++) hist[k] = 0;
    exp_q.delete();
  endtask

  // Streams stim through the DUT, recording outputs, acceptance edges and out_valid rise edges.
  task automatic run_stream(input bit rnd_ready);
    int idx;
    int budget;
    bit prev_v;
    idx = 0; budget = 3000; tmo = 1'b0;
    outs.delete(); acc_edges.delete(); valid_edges.delete(); exp_q.delete();
    prev_v = out_valid;
    while (outs.size() < stim.size() * NI) begin
      @(negedge clk);
      if (budget == 0) begin tmo = 1'b1; break; end
      budget--;
      if (out_valid && !prev_v) valid_edges.push_back(cyc);
      prev_v = out_valid;
      in_valid = (idx < stim.size());
      in_data = in_valid ? DW'(stim[idx]) : '0;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (in_valid && in_ready) begin
        acc_edges.push_back(cyc + 1);
        model_push(stim[idx]);
        idx++;
      end
      if (out_valid && out_ready) outs.push_back(int'(out_data));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
  endtask

  task automatic test_impulse(input string tag);
    int req [6];
    req = '{10, 5, 0, 5, 0, 0};
    coefs = '{16, 0, 0, 0, 8, 8, 0, 0};
    set_coefs();
    stim.delete(); stim.push_back(10); stim.push_back(0); stim.push_back(0);
    run_stream(1'b0);
    checks++; if (tmo || outs.size() != 6) begin errors++; $display("FAIL %s_count: got %0d outputs expected 6", tag, outs.size()); end
    for (int i = 0; i < 6 && i < outs.size(); i++) begin
      checks++; if (outs[i] != req[i]) begin errors++; $display("FAIL %s_out%0d: got %0d expected %0d", tag, i, outs[i], req[i]); end
    end
    if (acc_edges.size() > 0 && valid_edges.size() > 0) begin
      checks++; if (valid_edges[0] - acc_edges[0] != NT) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", tag, valid_edges[0] - acc_edges[0], NT); end
    end else begin
      checks++; errors++; $display("FAIL %s_latency: got no edges expected %0d", tag, NT);
    end
  endtask

  task automatic test_pos_sat();
    do_reset();
    for (int i = 0; i < NI*NT; i++) coefs[i] = 16;
    set_coefs();
    stim.delete(); stim.push_back(31); stim.push_back(31);
    run_stream(1'b0);
    checks++; if (tmo || outs.size() != 4) begin errors++; $display("FAIL pos_sat_count: got %0d expected 4", outs.size()); end
    else begin
      for (int i = 2; i < 4; i++) begin
        checks++; if (outs[i] != 31) begin errors++; $display("FAIL pos_sat_out%0d: got %0d expected 31", i, outs[i]); end
      end
      for (int i = 0; i < 4; i++) begin
        checks++; if (outs[i] != exp_q[i]) begin errors++; $display("FAIL pos_sat_model%0d: got %0d expected %0d", i, outs[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_neg_sat_trunc();
    do_reset();
    for (int i = 0; i < NI*NT; i++) coefs[i] = 16;
    set_coefs();
    stim.delete(); stim.push_back(-32); stim.push_back(-32);
    run_stream(1'b0);
    checks++; if (tmo || outs.size() != 4) begin errors++; $display("FAIL neg_sat_count: got %0d expected 4", outs.size()); end
    else begin
      for (int i = 2; i < 4; i++) begin
        checks++; if (outs[i] != -32) begin errors++; $display("FAIL neg_sat_out%0d: got %0d expected -32", i, outs[i]); end
      end
    end
    do_reset();
    coefs = '{16, 0, 0, 0, 8, 0, 0, 0};
    set_coefs();
    stim.delete(); stim.push_back(-1);
    run_stream(1'b0);
    checks++; if (tmo || outs.size() != 2) begin errors++; $display("FAIL trunc_count: got %0d expected 2", outs.size()); end
    else begin
      checks++; if (outs[1] != -1) begin errors++; $display("FAIL trunc_phase1: got %0d expected -1", outs[1]); end
      checks++; if (outs[0] != exp_q[0]) begin errors++; $display("FAIL trunc_phase0: got %0d expected %0d", outs[0], exp_q[0]); end
    end
  endtask

  task automatic test_backpressure();
    int d, held, b;
    do_reset();
    rand_coefs();
    d = $urandom_range(0, 63) - 32;
    model_push(d);
    @(negedge clk); in_valid = 1'b1; in_data = DW'(d); out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    b = 0;
    while (!out_valid && b < 50) begin @(negedge clk); b++; end
    checks++; if (!out_valid) begin errors++; $display("FAIL bp_wait_valid: got timeout expected out_valid"); end
    held = int'(out_data);
    checks++; if (held != exp_q[0]) begin errors++; $display("FAIL bp_phase0: got %0d expected %0d", held, exp_q[0]); end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || int'(out_data) != held || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b data=%0d in_ready=%b busy=%b expected 1/%0d/0/1", out_valid, out_data, in_ready, busy, held);
      end
    end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_one_hs: got valid=%b busy=%b expected 0/1", out_valid, busy); end
    b = 0;
    while (!out_valid && b < 50) begin @(negedge clk); b++; end
    checks++; if (!out_valid || int'(out_data) != exp_q[1]) begin errors++; $display("FAIL bp_phase1: got %0d expected %0d", out_data, exp_q[1]); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_return_idle: got in_ready=%b valid=%b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_handshake_gating();
    do_reset();
    rand_coefs();
    stim.delete(); stim.push_back(1); stim.push_back(2); stim.push_back(3);
    run_stream(1'b0);
    checks++; if (tmo || outs.size() != 6) begin errors++; $display("FAIL gate_count: got %0d expected 6", outs.size()); end
    for (int i = 0; i < outs.size() && i < exp_q.size(); i++) begin
      checks++; if (outs[i] != exp_q[i]) begin errors++; $display("FAIL gate_out%0d: got %0d expected %0d", i, outs[i], exp_q[i]); end
    end
    checks++; if (acc_edges.size() != 3) begin errors++; $display("FAIL gate_accepts: got %0d expected 3", acc_edges.size()); end
    else begin
      for (int i = 1; i < 3; i++) begin
        checks++; if (acc_edges[i] - acc_edges[i-1] != NI*(NT+1)+1) begin errors++; $display("FAIL gate_interval%0d: got %0d expected %0d", i, acc_edges[i] - acc_edges[i-1], NI*(NT+1)+1); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 6; r++) begin
      rand_coefs();
      stim.delete();
      for (int i = 0; i < 5; i++) stim.push_back($urandom_range(0, 63) - 32);
      run_stream(1'b1);
      checks++; if (tmo || outs.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", r, outs.size(), exp_q.size()); end
      for (int i = 0; i < outs.size() && i < exp_q.size(); i++) begin
        checks++; if (outs[i] != exp_q[i]) begin errors++; $display("FAIL rand%0d_out%0d: got %0d expected %0d", r, i, outs[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    do_reset();
    rand_coefs();
    @(negedge clk); in_valid = 1'b1; in_data = DW'(10); out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    // Acceptance edge E is behind us; phase 0 handshakes at E+5, phase-1 tap 2 is processed at E+8.
    repeat (7) @(negedge clk);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_pre: got busy=%b valid=%b expected 1/0", busy, out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got valid=%b busy=%b in_ready=%b expected 0/0/1", out_valid, busy, in_ready);
    end
    for (int k = 0; k < NT; k++) hist[k] = 0;
    test_impulse("mid_impulse");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; coef = '0;
    test_reset();
    test_impulse("impulse");
    test_pos_sat();
    test_neg_sat_trunc();
    test_backpressure();
    test_handshake_gating();
    test_random();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
